garduino_pio_in_capture: RTL and testbench
==========================================

Name: garduino_pio_in_capture

Overview:
- Avalon-MM slave input PIO with 32-bit data and 2-bit word address. It is the input-direction counterpart of the system's output PIOs.
- Samples external greenhouse inputs (float switches, door contacts, push-buttons), synchronizes and debounces them, and latches edge events into a capture register.
- Raises a level interrupt to the Nios II through a maskable enable register.

Parameters:
- WIDTH, 8, number of input bits (1..32).
- DEBOUNCE_CYCLES, 16, consecutive stable clk cycles required before a debounced bit changes (>=1).
- EDGE_TYPE, 0, edges captured: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- address  input  2  Avalon word address.
- chipselect  input  1  Avalon slave select.
- write_n  input  1  Avalon write strobe, active-low.
- writedata  input  32  Avalon write data.
- readdata  output  32  Avalon read data, zero-extended above WIDTH, 0 wait states, 0 read latency (combinational from registers).
- in_port  input  WIDTH  asynchronous external inputs.
- irq  output  1  level interrupt = OR over (edgecapture & irqmask).

Behaviour:
- Reset: all internal registers clear on a clk edge with reset=1.
  - Cleared registers: sync_q1, sync_q2, debounced, counters, irqmask, edgecapture.
  - Outputs during and after reset: irq=0; readdata reflects the cleared registers (0 for addresses 0..3).
  - Reset asserted mid-debounce discards the pending count. No capture occurs in a cycle with reset=1.
- Synchronizer: in_port -> sync_q1 -> sync_q2, one flop stage per clk edge.
- Debounce, per bit i, each clk edge:
  - If sync_q2[i] != debounced[i] and cnt[i] == DEBOUNCE_CYCLES-1: debounced[i] <= sync_q2[i]; cnt[i] <= 0; update[i] pulses for this edge.
  - Else if sync_q2[i] != debounced[i]: cnt[i] <= cnt[i]+1.
  - Else: cnt[i] <= 0. A glitch shorter than DEBOUNCE_CYCLES is fully rejected.
  - Counter width: clog2(DEBOUNCE_CYCLES) bits, minimum 1.
- Latency: an in_port[i] change that is stable from the edge it is first sampled appears in debounced[i] exactly 1+DEBOUNCE_CYCLES edges after that first-sample edge.
- Edge detection:
  - Rising edge: update[i] with new value 1. Falling edge: update[i] with new value 0.
  - EDGE_TYPE selects which edges count.
  - edgecapture[i] sets on the same clk edge debounced[i] updates.
- Because debounced resets to 0, an input held high through reset produces a rising-edge capture after reset. Software clears edgecapture during init.
- Register map (read: readdata; write: chipselect=1 & write_n=0):
  - addr 0 data: read = debounced. Writes ignored.
  - addr 1 reserved: read 0. Writes ignored.
  - addr 2 irqmask: read/write bits [WIDTH-1:0]. Upper writedata bits ignored.
  - addr 3 edgecapture: read = captured bits. Write-1-to-clear per bit; writing 0 leaves a bit unchanged.
- Simultaneous events:
  - Clear and new capture on the same bit in the same cycle: set wins, bit stays 1.
  - Clears on other bits still apply.
- irq: combinational from registered edgecapture and irqmask. It asserts the cycle after the capturing edge and deasserts the cycle after the clearing write or mask write.
- Reads have no side effects. chipselect=0 makes writes no-ops; readdata is still driven from address.

Test Plan:
- Reset check: reset=1 for 2 cycles with in_port=8'h00, then deassert -> readdata at addr 0/2/3 = 0, irq=0.
- Debounce and capture (DEBOUNCE_CYCLES=16, EDGE_TYPE=0):
  - Stimulus: irqmask=8'h01, then in_port[0] 0->1 held.
  - Required: addr 0 reads 8'h01 exactly 17 edges after the first-sample edge; edgecapture=8'h01 at that edge; irq=1 next cycle.
- Glitch rejection: in_port[3] pulses high for 15 cycles, then low -> debounced stays 8'h00, edgecapture stays 8'h00, irq stays 0.
- Write-1-to-clear: edgecapture=8'h05, write 8'h04 to addr 3 -> edgecapture=8'h01, irq tracks mask 8'h01.
- Collision: write 8'h01 to addr 3 on the same edge bit 0 captures a new edge -> edgecapture[0] remains 1.
- Reserved/ignored accesses:
  - Writes of 32'hFFFFFFFF to addr 0 and addr 1: no state change; addr 1 reads 0.
  - EDGE_TYPE=2: both the 0->1 and 1->0 transitions of bit 7 set edgecapture[7].
- Reset mid-debounce: assert reset at count 10 -> counter cleared; after release the full 17-edge latency is required again.

Source files
------------

// File: rtl/garduino_pio_in_capture_if.sv
// ---------------------------------------------------------------------------
// garduino_pio_in_capture_if
// Avalon-MM slave bus bundle for the greenhouse input-capture PIO.
//   address    [1:0]  word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect        slave select
//   write_n           write strobe, active-low
//   writedata  [31:0] write data
//   readdata   [31:0] read data, zero wait states, combinational from registers
// The master modport is the Nios II side; the slave modport is the PIO.
// ---------------------------------------------------------------------------
interface garduino_pio_in_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/garduino_pio_in_capture.sv
// ---------------------------------------------------------------------------
// garduino_pio_in_capture
// Input PIO for the greenhouse controller: float switches, door contacts and
// push-buttons are synchronized, debounced per bit and their edges latched
// into a write-1-to-clear capture register that drives a maskable level irq.
//
// Parameters
//   WIDTH            number of input bits (1..32)
//   DEBOUNCE_CYCLES  consecutive stable cycles before a debounced bit changes
//   EDGE_TYPE        0 = rising, 1 = falling, 2 = any edge is captured
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   bus      Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port  asynchronous external inputs
//   irq      level interrupt = |(edgecapture & irqmask)
// ---------------------------------------------------------------------------
module garduino_pio_in_capture #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    garduino_pio_in_capture_if.slave        bus,
    input  logic [WIDTH-1:0]                in_port,
    output logic                            irq
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    // Registered state
    logic [WIDTH-1:0] sync1_q,       sync1_d;
    logic [WIDTH-1:0] sync2_q,       sync2_d;
    logic [WIDTH-1:0] debounced_q,   debounced_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] irqmask_q,     irqmask_d;
    logic [WIDTH-1:0] edgecapture_q, edgecapture_d;

    // Combinational helpers
    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] clear;
    logic             wr_en;
    logic [31:0]      rdata;

    // Only the low WIDTH bits of writedata are architected.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    assign wr_en = bus.chipselect & ~bus.write_n;

    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sync1_d     = in_port;
        sync2_d     = sync1_q;
        debounced_d = debounced_q;
        update      = '0;

        // A bit only moves once it has disagreed with the debounced value for
        // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the run.
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != debounced_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    debounced_d[i] = sync2_q[i];
                    update[i]      = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        if (EDGE_TYPE == 0) begin
            capture = update & debounced_d;
        end else if (EDGE_TYPE == 1) begin
            capture = update & ~debounced_d;
        end else begin
            capture = update;
        end

        irqmask_d = irqmask_q;
        if (wr_en && bus.address == ADDR_MASK) begin
            irqmask_d = bus.writedata[WIDTH-1:0];
        end

        clear = '0;
        if (wr_en && bus.address == ADDR_EDGE) begin
            clear = bus.writedata[WIDTH-1:0];
        end

        // A new capture wins over a simultaneous clear of the same bit.
        edgecapture_d = (edgecapture_q & ~clear) | capture;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            debounced_q   <= '0;
            irqmask_q     <= '0;
            edgecapture_q <= '0;
            // NOTE: the counter array is reset on purpose: a pending debounce
            // run must be discarded, so this is state, not storage.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            debounced_q   <= debounced_d;
            irqmask_q     <= irqmask_d;
            edgecapture_q <= edgecapture_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Zero-latency read mux; reads never disturb state.
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA: rdata[WIDTH-1:0] = debounced_q;
            ADDR_MASK: rdata[WIDTH-1:0] = irqmask_q;
            ADDR_EDGE: rdata[WIDTH-1:0] = edgecapture_q;
            default:   rdata            = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign irq          = |(edgecapture_q & irqmask_q);

endmodule

// File: tb/tb_garduino_pio_in_capture.sv
// ---------------------------------------------------------------------------
// tb_garduino_pio_in_capture
// Three instances (rising, falling, any-edge capture) share one stimulus
// stream. A reference model derives the debounced value from the recent
// history of synchronized samples and is compared against every instance on
// every falling clock edge; directed literal checks pin key latencies.
// ---------------------------------------------------------------------------
module tb_garduino_pio_in_capture;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = '0;

    logic [31:0]  rd_dut  [3];
    logic         irq_dut [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    garduino_pio_in_capture_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].address    = address;
        assign bus[g].chipselect = chipselect;
        assign bus[g].write_n    = write_n;
        assign bus[g].writedata  = writedata;
        assign rd_dut[g]         = bus[g].readdata;

        garduino_pio_in_capture #(
            .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(g)
        ) dut (
            .clk    (clk),
            .reset  (reset),
            .bus    (bus[g]),
            .in_port(in_port),
            .irq    (irq_dut[g])
        );
    end

    // ---------------- reference model ----------------
    logic [W-1:0] s1_m, s2_m, deb_m, mask_m, upd_m, nd_m, clr_m;
    logic [W-1:0] ec_m [3];
    logic [W-1:0] hist [$];
    bit           model_valid = 0;
    bit           all_diff;

    always @(posedge clk) begin
        if (reset) begin
            s1_m = '0; s2_m = '0; deb_m = '0; mask_m = '0;
            for (int g = 0; g < 3; g++) ec_m[g] = '0;
            hist.delete();
            model_valid = 1;
        end else begin
            hist.push_back(s2_m);
            if (hist.size() > D) void'(hist.pop_front());
            // A bit flips once the last D samples all oppose its current value.
            upd_m = '0;
            if (hist.size() == D) begin
                for (int i = 0; i < W; i++) begin
                    all_diff = 1;
                    foreach (hist[k]) if (hist[k][i] == deb_m[i]) all_diff = 0;
                    upd_m[i] = all_diff;
                end
            end
            nd_m  = deb_m ^ upd_m;
            clr_m = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            ec_m[0] = (ec_m[0] & ~clr_m) | (upd_m & nd_m);
            ec_m[1] = (ec_m[1] & ~clr_m) | (upd_m & ~nd_m);
            ec_m[2] = (ec_m[2] & ~clr_m) | upd_m;
            if (chipselect && !write_n && address == 2'd2) mask_m = writedata[W-1:0];
            deb_m = nd_m;
            s2_m  = s1_m;
            s1_m  = in_port;
        end
    end

    function automatic logic [31:0] exp_rd(int g);
        case (address)
            2'd0:    return {{(32-W){1'b0}}, deb_m};
            2'd2:    return {{(32-W){1'b0}}, mask_m};
            2'd3:    return {{(32-W){1'b0}}, ec_m[g]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: every instance, every cycle.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int g = 0; g < 3; g++) begin
                check($sformatf("model_rd%0d_a%0d", g, address), rd_dut[g], exp_rd(g));
                check($sformatf("model_irq%0d", g), {31'd0, irq_dut[g]},
                      {31'd0, |(ec_m[g] & mask_m)});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(int g, logic [1:0] a, logic [31:0] exp, string name);
        address = a;
        #1;
        check(name, rd_dut[g], exp);
    endtask

    task automatic irq_is(int g, logic exp, string name);
        check(name, {31'd0, irq_dut[g]}, {31'd0, exp});
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        reset = 1'b0;
        rd(0, 2'd0, 32'h0, "rst_data");
        rd(0, 2'd2, 32'h0, "rst_mask");
        rd(0, 2'd3, 32'h0, "rst_edge");
        irq_is(0, 1'b0, "rst_irq");

        // Debounce latency and capture on bit 0
        wr(2'd2, 32'h1);
        in_port = 8'h01;
        repeat (17) tick();
        rd(0, 2'd0, 32'h00, "lat_edge16");
        tick();
        rd(0, 2'd0, 32'h01, "lat_edge17");
        rd(0, 2'd3, 32'h01, "cap_edge17");
        irq_is(0, 1'b1, "cap_irq");

        // Glitch rejection on bit 3
        wr(2'd3, 32'hFF);
        rd(0, 2'd3, 32'h00, "clr_edge");
        irq_is(0, 1'b0, "clr_irq");
        in_port = 8'h09;
        repeat (15) tick();
        in_port = 8'h01;
        repeat (20) tick();
        rd(0, 2'd0, 32'h01, "glitch_data");
        rd(0, 2'd3, 32'h00, "glitch_edge");
        irq_is(0, 1'b0, "glitch_irq");

        // Write-1-to-clear of a subset
        in_port = 8'h00;
        repeat (20) tick();
        wr(2'd3, 32'hFF);
        in_port = 8'h05;
        repeat (18) tick();
        rd(0, 2'd3, 32'h05, "w1c_before");
        irq_is(0, 1'b1, "w1c_irq_before");
        wr(2'd3, 32'h04);
        rd(0, 2'd3, 32'h01, "w1c_after");
        irq_is(0, 1'b1, "w1c_irq_after");
        wr(2'd2, 32'h0);
        irq_is(0, 1'b0, "mask_off_irq");
        wr(2'd2, 32'h1);

        // Clear and capture of bit 0 on the same edge
        in_port = 8'h04;
        repeat (20) tick();
        wr(2'd3, 32'hFF);
        in_port = 8'h05;
        repeat (17) tick();
        wr(2'd3, 32'h01);
        rd(0, 2'd3, 32'h01, "collision_edge");

        // Writes to data and reserved addresses are ignored
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(0, 2'd1, 32'h0, "reserved_read");
        rd(0, 2'd0, 32'h05, "data_ro");
        rd(0, 2'd2, 32'h01, "mask_kept");

        // Edge-type variants on bit 7
        wr(2'd3, 32'hFF);
        in_port = 8'h85;
        repeat (18) tick();
        rd(2, 2'd3, 32'h80, "any_rise");
        rd(0, 2'd3, 32'h80, "rise_rise");
        rd(1, 2'd3, 32'h00, "fall_rise");
        wr(2'd3, 32'hFF);
        in_port = 8'h05;
        repeat (18) tick();
        rd(2, 2'd3, 32'h80, "any_fall");
        rd(1, 2'd3, 32'h80, "fall_fall");
        rd(0, 2'd3, 32'h00, "rise_fall");

        // Reset in the middle of a debounce run
        in_port = 8'h00;
        repeat (20) tick();
        in_port = 8'h02;
        repeat (12) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(0, 2'd0, 32'h0, "midrst_data");
        rd(0, 2'd2, 32'h0, "midrst_mask");
        repeat (17) tick();
        rd(0, 2'd0, 32'h00, "relat_edge16");
        tick();
        rd(0, 2'd0, 32'h02, "relat_edge17");
        rd(0, 2'd3, 32'h02, "relat_cap");
        irq_is(0, 1'b0, "relat_irq");

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(19) == 0) in_port[$urandom_range(W-1)] ^= 1'b1;
            chipselect = ($urandom_range(3) == 0);
            write_n    = $urandom_range(1) == 1;
            address    = 2'($urandom_range(3));
            writedata  = $urandom;
            reset      = ($urandom_range(799) == 0);
            tick();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
